// File: rtl/cpu_control_unit_if.sv
// rtl/cpu_control_unit_if.sv - instruction-in / control-out bundle between control unit and datapath
interface cpu_control_unit_if #(
  parameter int DADDR_W = 8,
  parameter int RADDR_W = 4
);
  logic [15:0]        i_ir;
  logic               o_pc_clr;
  logic               o_pc_up;
  logic               o_ir_ld;
  logic [DADDR_W-1:0] o_d_addr;
  logic               o_d_wr;
  logic               o_rf_s;
  logic [RADDR_W-1:0] o_rf_w_addr;
  logic               o_rf_w_en;
  logic [RADDR_W-1:0] o_rf_ra_addr;
  logic [RADDR_W-1:0] o_rf_rb_addr;
  logic [2:0]         o_alu_s0;
  logic [3:0]         o_state;

  modport master (
    input  i_ir,
    output o_pc_clr, o_pc_up, o_ir_ld, o_d_addr, o_d_wr, o_rf_s,
           o_rf_w_addr, o_rf_w_en, o_rf_ra_addr, o_rf_rb_addr, o_alu_s0, o_state
  );

  modport slave (
    output i_ir,
    input  o_pc_clr, o_pc_up, o_ir_ld, o_d_addr, o_d_wr, o_rf_s,
           o_rf_w_addr, o_rf_w_en, o_rf_ra_addr, o_rf_rb_addr, o_alu_s0, o_state
  );
endinterface

// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - multi-cycle fetch/decode/execute Moore control FSM
module cpu_control_unit #(
  parameter int DADDR_W = 8,
  parameter int RADDR_W = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  cpu_control_unit_if.master   bus
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t r_state;

  // IR is only consulted in DECODE, so IR activity elsewhere cannot steer the sequence
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_INIT;
    end else begin
      case (r_state)
        S_INIT:   r_state <= S_FETCH;
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          case (bus.i_ir[15:12])
            4'h1:    r_state <= S_STORE;
            4'h2:    r_state <= S_LOAD_A;
            4'h3:    r_state <= S_ADD;
            4'h4:    r_state <= S_SUB;
            4'h5:    r_state <= S_HALT;
            default: r_state <= S_NOOP;
          endcase
        end
        S_NOOP:   r_state <= S_FETCH;
        S_LOAD_A: r_state <= S_LOAD_B;
        S_LOAD_B: r_state <= S_FETCH;
        S_STORE:  r_state <= S_FETCH;
        S_ADD:    r_state <= S_FETCH;
        S_SUB:    r_state <= S_FETCH;
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_INIT;
      endcase
    end
  end

  logic               w_pc_clr;
  logic               w_pc_up;
  logic               w_ir_ld;
  logic [DADDR_W-1:0] w_d_addr;
  logic               w_d_wr;
  logic               w_rf_s;
  logic [RADDR_W-1:0] w_rf_w_addr;
  logic               w_rf_w_en;
  logic [RADDR_W-1:0] w_rf_ra_addr;
  logic [RADDR_W-1:0] w_rf_rb_addr;
  logic [2:0]         w_alu_s0;

  // Decoded from the state register so an async reset kills write strobes immediately
  always_comb begin
    w_pc_clr     = 1'b0;
    w_pc_up      = 1'b0;
    w_ir_ld      = 1'b0;
    w_d_addr     = '0;
    w_d_wr       = 1'b0;
    w_rf_s       = 1'b0;
    w_rf_w_addr  = '0;
    w_rf_w_en    = 1'b0;
    w_rf_ra_addr = '0;
    w_rf_rb_addr = '0;
    w_alu_s0     = 3'd0;
    case (r_state)
      S_INIT: w_pc_clr = 1'b1;
      S_FETCH: begin
        w_ir_ld = 1'b1;
        w_pc_up = 1'b1;
      end
      S_LOAD_A, S_LOAD_B: begin
        w_d_addr    = bus.i_ir[11:4];
        w_rf_s      = 1'b1;
        w_rf_w_addr = bus.i_ir[3:0];
        w_rf_w_en   = (r_state == S_LOAD_B);
      end
      S_STORE: begin
        w_d_addr     = bus.i_ir[7:0];
        w_rf_ra_addr = bus.i_ir[11:8];
        w_d_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        w_rf_ra_addr = bus.i_ir[11:8];
        w_rf_rb_addr = bus.i_ir[7:4];
        w_rf_w_addr  = bus.i_ir[3:0];
        w_rf_w_en    = 1'b1;
        w_alu_s0     = (r_state == S_ADD) ? 3'd1 : 3'd2;
      end
      default: ;
    endcase
  end

  assign bus.o_pc_clr     = w_pc_clr;
  assign bus.o_pc_up      = w_pc_up;
  assign bus.o_ir_ld      = w_ir_ld;
  assign bus.o_d_addr     = w_d_addr;
  assign bus.o_d_wr       = w_d_wr;
  assign bus.o_rf_s       = w_rf_s;
  assign bus.o_rf_w_addr  = w_rf_w_addr;
  assign bus.o_rf_w_en    = w_rf_w_en;
  assign bus.o_rf_ra_addr = w_rf_ra_addr;
  assign bus.o_rf_rb_addr = w_rf_rb_addr;
  assign bus.o_alu_s0     = w_alu_s0;
  assign bus.o_state      = r_state;

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - directed scoreboard bench for cpu_control_unit
module tb_cpu_control_unit;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [32:0] sb_q[$];

  cpu_control_unit_if #(.DADDR_W(8), .RADDR_W(4)) bus ();

  cpu_control_unit #(.DADDR_W(8), .RADDR_W(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] observed();
    return {bus.o_state, bus.o_pc_clr, bus.o_pc_up, bus.o_ir_ld, bus.o_d_addr,
            bus.o_d_wr, bus.o_rf_s, bus.o_rf_w_addr, bus.o_rf_w_en,
            bus.o_rf_ra_addr, bus.o_rf_rb_addr, bus.o_alu_s0};
  endfunction

  function automatic logic [32:0] model(input logic [3:0] st, input logic [15:0] ir);
    logic       pc_clr, pc_up, ir_ld, d_wr, rf_s, w_en;
    logic [7:0] d_addr;
    logic [3:0] w_addr, ra, rb;
    logic [2:0] alu;
    {pc_clr, pc_up, ir_ld, d_wr, rf_s, w_en} = '0;
    d_addr = '0; w_addr = '0; ra = '0; rb = '0; alu = '0;
    case (st)
      4'd0: pc_clr = 1'b1;
      4'd1: begin ir_ld = 1'b1; pc_up = 1'b1; end
      4'd4: begin d_addr = ir[11:4]; rf_s = 1'b1; w_addr = ir[3:0]; end
      4'd5: begin d_addr = ir[11:4]; rf_s = 1'b1; w_addr = ir[3:0]; w_en = 1'b1; end
      4'd6: begin d_addr = ir[7:0]; ra = ir[11:8]; d_wr = 1'b1; end
      4'd7: begin ra = ir[11:8]; rb = ir[7:4]; w_addr = ir[3:0]; w_en = 1'b1; alu = 3'd1; end
      4'd8: begin ra = ir[11:8]; rb = ir[7:4]; w_addr = ir[3:0]; w_en = 1'b1; alu = 3'd2; end
      default: ;
    endcase
    return {st, pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, w_addr, w_en, ra, rb, alu};
  endfunction

  task automatic compare_front(input string tag);
    logic [32:0] exp_v;
    logic [32:0] obs_v;
    exp_v = sb_q.pop_front();
    obs_v = observed();
    n_vec++;
    assert (obs_v === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
    end
  endtask

  task automatic cyc(input logic [3:0] st, input string tag);
    sb_q.push_back(model(st, bus.i_ir));
    @(posedge clk);
    #2;
    compare_front(tag);
  endtask

  task automatic now_chk(input logic [3:0] st, input string tag);
    sb_q.push_back(model(st, bus.i_ir));
    compare_front(tag);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.i_ir = 16'h0000;

    cyc(4'd0, "reset_init");
    cyc(4'd0, "reset_hold");
    rst = 1'b0;
    cyc(4'd1, "fetch_after_release");

    bus.i_ir = 16'h2A53;
    cyc(4'd2, "load_decode");
    cyc(4'd4, "load_a");
    chk("load_a_daddr", {24'd0, bus.o_d_addr}, 32'h0000_00A5);
    chk("load_a_wen", {31'd0, bus.o_rf_w_en}, 32'd0);
    cyc(4'd5, "load_b");
    chk("load_b_wen", {31'd0, bus.o_rf_w_en}, 32'd1);
    cyc(4'd1, "load_to_fetch");

    bus.i_ir = 16'h17C4;
    cyc(4'd2, "store_decode");
    cyc(4'd6, "store");
    chk("store_daddr", {24'd0, bus.o_d_addr}, 32'h0000_00C4);
    chk("store_ra", {28'd0, bus.o_rf_ra_addr}, 32'd7);
    cyc(4'd1, "store_to_fetch");

    bus.i_ir = 16'h3123;
    cyc(4'd2, "add_decode");
    cyc(4'd7, "add");
    chk("add_alu", {29'd0, bus.o_alu_s0}, 32'd1);
    bus.i_ir = 16'h5000;
    cyc(4'd1, "add_ir_change_to_fetch");

    bus.i_ir = 16'h4123;
    cyc(4'd2, "sub_decode");
    cyc(4'd8, "sub");
    chk("sub_alu", {29'd0, bus.o_alu_s0}, 32'd2);
    cyc(4'd1, "sub_to_fetch");

    bus.i_ir = 16'hF000;
    cyc(4'd2, "illegal_decode");
    cyc(4'd3, "illegal_noop");
    cyc(4'd1, "illegal_to_fetch");

    bus.i_ir = 16'h0000;
    cyc(4'd2, "noop_decode");
    cyc(4'd3, "noop");
    cyc(4'd1, "noop_to_fetch");

    bus.i_ir = 16'h5000;
    cyc(4'd2, "halt_decode");
    for (int i = 0; i < 20; i++) cyc(4'd9, "halt_hold");

    #3;
    rst = 1'b1;
    #1;
    now_chk(4'd0, "async_reset_from_halt");
    @(posedge clk);
    #2;
    rst = 1'b0;
    cyc(4'd1, "fetch_after_halt_reset");

    bus.i_ir = 16'h2A53;
    cyc(4'd2, "load2_decode");
    cyc(4'd4, "load2_a");
    cyc(4'd5, "load2_b");
    rst = 1'b1;
    #1;
    now_chk(4'd0, "async_reset_in_load_b");
    chk("reset_drops_wen", {31'd0, bus.o_rf_w_en}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    cyc(4'd1, "restart_fetch");
    cyc(4'd2, "restart_decode");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
